dmem_access_ctrl: RTL

- Sequences every MEM-stage load/store onto a single-beat data-memory bus that takes a variable number of wait states.
- Generates byte lanes and replicated store data, and extracts and extends load data.
- Stalls the pipeline until the access completes and flags alignment and bus-timeout errors.
- Sits between the MEM stage and the data-memory bus interface.

---
 rtl/dmem_access_ctrl_pkg.sv | 22 ++
 rtl/dmem_access_ctrl_lane_sel.sv | 47 ++++
 rtl/dmem_access_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared opcode constants, FSM state encoding and defaults for the data-memory
// access controller.
package dmem_access_ctrl_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    localparam int unsigned DEFAULT_TIMEOUT = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StResp = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_access_ctrl_lane_sel.sv
// Decodes a MEM-stage opcode and the low address bits into byte enables,
// replicated store data and an alignment-fault flag.
module dmem_access_ctrl_lane_sel
    import dmem_access_ctrl_pkg::*;
(
    input  logic [5:0]  i_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    output logic        o_load,
    output logic        o_store,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_misalign
);

    always_comb begin
        o_load     = 1'b0;
        o_store    = 1'b0;
        o_be       = 4'b0000;
        o_wdata    = 32'h0;
        o_misalign = 1'b0;
        case (i_op)
            OP_LB, OP_LBU, OP_SB: begin
                o_load  = (i_op != OP_SB);
                o_store = (i_op == OP_SB);
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            OP_LH, OP_LHU, OP_SH: begin
                o_load     = (i_op != OP_SH);
                o_store    = (i_op == OP_SH);
                o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata    = {2{i_wdata[15:0]}};
                o_misalign = i_addr_lo[0];
            end
            OP_LW, OP_SW: begin
                o_load     = (i_op == OP_LW);
                o_store    = (i_op == OP_SW);
                o_be       = 4'b1111;
                o_wdata    = i_wdata;
                o_misalign = |i_addr_lo;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Sequences MEM-stage loads/stores onto a single-beat, variable-latency data bus,
// stalling the pipeline until the access completes or times out.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_mem_valid,
    input  logic [5:0]  i_op,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic [31:0] o_rdata,
    output logic        o_rdata_valid,
    output logic        o_adel,
    output logic        o_ades,
    output logic        o_bus_err,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic        w_load;
    logic        w_store;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_misalign;
    logic        w_decoded;
    logic        w_accept;
    logic        w_fault;
    logic [31:0] w_ext;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    state_e      r_state;
    logic [7:0]  r_cnt;
    logic [5:0]  r_op;
    logic [1:0]  r_off;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_be;
    logic [31:0] r_bus_wdata;
    logic [31:0] r_rdata;
    logic        r_rdata_valid;
    logic        r_adel;
    logic        r_ades;
    logic        r_bus_err;

    dmem_access_ctrl_lane_sel u_lane_sel (
        .i_op       (i_op),
        .i_addr_lo  (i_addr[1:0]),
        .i_wdata    (i_wdata),
        .o_load     (w_load),
        .o_store    (w_store),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_misalign (w_misalign)
    );

    assign w_decoded = w_load | w_store;
    assign w_accept  = (r_state == StIdle) & i_mem_valid & w_decoded & ~w_misalign;
    assign w_fault   = (r_state == StIdle) & i_mem_valid & w_decoded & w_misalign;

    // Lane extraction uses the offset latched at request time, not the live address.
    assign w_byte = i_bus_rdata[{r_off, 3'b000} +: 8];
    assign w_half = r_off[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];

    always_comb begin
        w_ext = i_bus_rdata;
        case (r_op)
            OP_LB:   w_ext = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_ext = {24'h0, w_byte};
            OP_LH:   w_ext = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_ext = {16'h0, w_half};
            default: w_ext = i_bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_cnt         <= 8'd0;
            r_op          <= 6'd0;
            r_off         <= 2'd0;
            r_bus_req     <= 1'b0;
            r_bus_we      <= 1'b0;
            r_bus_addr    <= 32'h0;
            r_bus_be      <= 4'b0000;
            r_bus_wdata   <= 32'h0;
            r_rdata       <= 32'h0;
            r_rdata_valid <= 1'b0;
            r_adel        <= 1'b0;
            r_ades        <= 1'b0;
            r_bus_err     <= 1'b0;
        end else begin
            r_rdata_valid <= 1'b0;
            r_adel        <= 1'b0;
            r_ades        <= 1'b0;
            r_bus_err     <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_op        <= i_op;
                        r_off       <= i_addr[1:0];
                        r_bus_we    <= w_store;
                        r_bus_addr  <= {i_addr[31:2], 2'b00};
                        r_bus_be    <= w_be;
                        r_bus_wdata <= w_wdata;
                        r_bus_req   <= 1'b1;
                        r_cnt       <= 8'd0;
                        r_state     <= StBusy;
                    end else if (w_fault) begin
                        r_adel <= w_load;
                        r_ades <= w_store;
                    end
                end
                StBusy: begin
                    // Ack has priority over a timeout landing on the same edge.
                    if (i_bus_ack) begin
                        r_bus_req <= 1'b0;
                        r_cnt     <= 8'd0;
                        r_state   <= StResp;
                        if (!r_bus_we) begin
                            r_rdata       <= w_ext;
                            r_rdata_valid <= 1'b1;
                        end
                    end else if (r_cnt == TO_LAST) begin
                        r_bus_req <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_cnt     <= 8'd0;
                        r_state   <= StResp;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                StResp:  r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_stall       = (r_state == StBusy) | w_accept;
    assign o_rdata       = r_rdata;
    assign o_rdata_valid = r_rdata_valid;
    assign o_adel        = r_adel;
    assign o_ades        = r_ades;
    assign o_bus_err     = r_bus_err;
    assign o_bus_req     = r_bus_req;
    assign o_bus_we      = r_bus_we;
    assign o_bus_addr    = r_bus_addr;
    assign o_bus_be      = r_bus_be;
    assign o_bus_wdata   = r_bus_wdata;

endmodule
